reg_pipe_out_buffer: RTL

//  Downstream stage of the dynamically-extracted 2-register delay pipeline.

---
 rtl/reg_pipe_pkg.sv | 18 +
 rtl/reg_pipe_out_buffer_sat_counter.sv | 24 ++
 rtl/reg_pipe_out_buffer.sv | 89 ++++++++
 3 files changed

// File: rtl/reg_pipe_pkg.sv
// Shared constants for the extracted 2-register delay pipeline units.
//   PIPE_DATA_WIDTH : width of the pipeline output word
//   clog2()         : ceiling log2, usable in constant expressions
//   PIPE_DEPTH / PIPE_PTR_W / PIPE_OCC_W : default buffer geometry
package reg_pipe_pkg;
  localparam int PIPE_DATA_WIDTH = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int PIPE_DEPTH = 4;
  localparam int PIPE_PTR_W = clog2(PIPE_DEPTH);
  localparam int PIPE_OCC_W = clog2(PIPE_DEPTH) + 1;
endpackage

// File: rtl/reg_pipe_out_buffer_sat_counter.sv
// Saturating up-counter with clear.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one event (holds at all-ones)
//   clr        : clear; a simultaneous inc restarts the count at 1
//   cnt        : current count
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);
  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (clr)                    r_cnt <= inc ? WIDTH'(1) : '0;
    else if (inc && (r_cnt != '1))   r_cnt <= r_cnt + WIDTH'(1);
  end

  assign cnt = r_cnt;
endmodule

// File: rtl/reg_pipe_out_buffer.sv
// Output buffer behind the 2-register delay pipeline: a first-word-fall-through
// FIFO that captures din when din_vld is high (no upstream backpressure) and
// presents the head on a valid/ready port. Words arriving while full with no
// pop are dropped and counted.
//   clk, rst_n         : clock, async active-low reset
//   din, din_vld       : pipeline output word and its valid flag
//   dout, dout_vld     : head word (0 while empty), FIFO non-empty
//   dout_rd            : consumer accepts dout this cycle
//   occupancy          : stored words, 0..DEPTH
//   overflow, drop_cnt : sticky drop flag, saturating drop count
//   clr_ovf            : clears overflow and drop_cnt
module reg_pipe_out_buffer
  import reg_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
  parameter int DEPTH      = PIPE_DEPTH,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    din_vld,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_vld,
  input  logic                    dout_rd,
  output logic [clog2(DEPTH):0]   occupancy,
  output logic                    overflow,
  input  logic                    clr_ovf,
  output logic [CNT_WIDTH-1:0]    drop_cnt
);
  localparam int PTR_W = clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  r_ovf;

  logic w_empty, w_full, w_pop, w_push, w_drop;

  // Full/empty come from the occupancy count, so pointer equality is never
  // ambiguous.
  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == OCC_W'(DEPTH));
  assign w_pop   = dout_rd & ~w_empty;
  // A pop frees a slot in the same cycle, so full + pop still accepts din.
  assign w_push  = din_vld & (~w_full | w_pop);
  assign w_drop  = din_vld & ~w_push;

  // Storage carries no reset; validity is tracked by r_occ alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_occ <= r_occ + OCC_W'(1);
      else if (w_pop && !w_push) r_occ <= r_occ - OCC_W'(1);
    end
  end

  // A drop in the same cycle as a clear wins, leaving the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_drop),
    .clr   (clr_ovf),
    .cnt   (drop_cnt)
  );

  // Head is read from registered state only; empty forces zero, so there is
  // no path from din to dout.
  assign dout      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign dout_vld  = ~w_empty;
  assign occupancy = r_occ;
  assign overflow  = r_ovf;
endmodule
